// File: rtl/iter_divider_pkg.sv
// Shared types and helpers for the iterative radix-2 restoring divider.
package iter_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef struct packed {
    logic div0;
    logic ovf;
  } special_t;

  // Operands arrive zero-extended to MAX_WIDTH; only the low 'width' bits matter.
  function automatic special_t special_case(input logic [MAX_WIDTH-1:0] z,
                                            input logic [MAX_WIDTH-1:0] d,
                                            input logic                 sgn,
                                            input int unsigned          width);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] min_neg;
    special_t             f;
    mask    = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    min_neg = MAX_WIDTH'(1) << (width - 1);
    f.div0  = ((d & mask) == '0);
    f.ovf   = sgn && ((z & mask) == min_neg) && ((d & mask) == mask);
    return f;
  endfunction

endpackage

// File: rtl/iter_divider_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract |d|.
module div_restoring_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // One extra guard bit so the borrow of the trial subtract is visible.
  always_comb begin
    shifted  = {rem[WIDTH-1:0], bit_in};
    diff     = {1'b0, shifted} - {2'b00, dmag};
    q_bit    = ~diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned integer divider with request and result valid/ready handshakes.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  input  logic             div_signed_i,
  input  logic [WIDTH-1:0] z_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] s_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem, rem_next;
  logic [WIDTH-1:0] zq, dmag;
  logic [WIDTH-1:0] zmag, dmag_in;
  logic [WIDTH-1:0] q_final, r_final;
  logic             qsign, rsign, q_bit;
  logic             accept, last;
  special_t         spec;

  assign accept  = div_valid_i & div_ready_o;
  assign last    = (cnt == CW'(WIDTH-1));
  assign spec    = special_case(MAX_WIDTH'(z_i), MAX_WIDTH'(d_i), div_signed_i, WIDTH);
  assign zmag    = (div_signed_i & z_i[WIDTH-1]) ? -z_i : z_i;
  assign dmag_in = (div_signed_i & d_i[WIDTH-1]) ? -d_i : d_i;

  // zq shifts dividend bits out of the MSB while quotient bits enter at the LSB.
  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .bit_in   (zq[WIDTH-1]),
    .dmag     (dmag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign q_final = {zq[WIDTH-2:0], q_bit};
  assign r_final = rem_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    div_ready_o = (state == IDLE);
    res_valid_o = (state == DONE);
    unique case (state)
      IDLE:    if (accept) state_next = (spec.div0 | spec.ovf) ? DONE : BUSY;
      BUSY:    if (last) state_next = DONE;
      DONE:    if (res_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      zq    <= '0;
      dmag  <= '0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      q_o   <= '0;
      s_o   <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          if (spec.div0) begin
            q_o <= DIV0_QUOTIENT[WIDTH-1:0];
            s_o <= z_i;
          end else if (spec.ovf) begin
            q_o <= z_i;
            s_o <= '0;
          end else begin
            rem   <= '0;
            zq    <= zmag;
            dmag  <= dmag_in;
            qsign <= div_signed_i & (z_i[WIDTH-1] ^ d_i[WIDTH-1]);
            rsign <= div_signed_i & z_i[WIDTH-1];
            cnt   <= '0;
          end
        end
        BUSY: begin
          rem <= rem_next;
          zq  <= q_final;
          cnt <= cnt + 1'b1;
          if (last) begin
            q_o <= qsign ? -q_final : q_final;
            s_o <= rsign ? -r_final : r_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
